// File: rtl/load_data_unit.sv
// Single-outstanding load unit. It issues a word read on a req/gnt + rvalid bus, then extracts and extends the
// byte, half or word into a one-cycle writeback. Define LOAD_MISALIGN_TRAP_EN to fault misaligned LH/LHU/LW at issue.
module load_data_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    input  logic [2:0]                ld_fun3,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
    input  logic                      flush,
    output logic                      bus_req,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    input  logic                      bus_gnt,
    input  logic                      bus_rvalid,
    input  logic [DATA_WIDTH-1:0]     bus_rdata,
    input  logic                      bus_err,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      wb_err
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, RESP} state_t;

    state_t                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [2:0]                fun3_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]     res_data;
    logic                      res_err;
    logic                      accept, fun3_ok, misalign, issue_fault;
    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;
    logic [DATA_WIDTH-1:0]     ext_data;

    assign ld_ready    = (state == IDLE) & ~flush;
    assign accept      = ld_valid & ld_ready;
    assign fun3_ok     = ld_fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef LOAD_MISALIGN_TRAP_EN
    assign misalign    = ((ld_fun3[1:0] == 2'b01) & ld_addr[0]) |
                         ((ld_fun3 == 3'b010) & (ld_addr[1:0] != 2'b00));
`else
    assign misalign    = 1'b0;
`endif
    assign issue_fault = ~fun3_ok | misalign;

    assign bus_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign wb_rd    = rd_q;
    assign wb_data  = res_data;
    assign wb_err   = res_err;

    // Lane select comes from the captured address; the bus always returns the aligned word.
    always_comb begin
        byte_sel = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = bus_rdata[{addr_q[1], 4'b0000} +: 16];
        ext_data = bus_rdata;
        case (fun3_q)
            3'b000:  ext_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  ext_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  ext_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: ext_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus_req   = 1'b0;
        wb_valid  = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = issue_fault ? RESP : REQ;
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt)    state_nxt = flush ? DRAIN : WAIT;
                else if (flush) state_nxt = IDLE;
            end
            // A flush that lands with rvalid simply drops the beat; no drain is needed.
            WAIT: begin
                if (bus_rvalid) state_nxt = flush ? IDLE : RESP;
                else if (flush) state_nxt = DRAIN;
            end
            DRAIN: if (bus_rvalid) state_nxt = IDLE;
            RESP: begin
                wb_valid  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            fun3_q   <= '0;
            rd_q     <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else if (accept) begin
            addr_q   <= ld_addr;
            fun3_q   <= ld_fun3;
            rd_q     <= ld_rd;
            res_data <= '0;
            res_err  <= issue_fault;
        end else if (state == WAIT && bus_rvalid && !flush) begin
            res_data <= bus_err ? '0 : ext_data;
            res_err  <= bus_err;
        end
    end
endmodule

// File: tb/tb_load_data_unit.sv
// Bench for load_data_unit: a cycle-level bus responder plus an arithmetic reference for extraction and flush timing.
module tb_load_data_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ld_valid = 1'b0, ld_ready, flush = 1'b0;
    logic [31:0] ld_addr = '0, bus_addr, bus_rdata = '0, wb_data;
    logic [2:0]  ld_fun3 = '0;
    logic [4:0]  ld_rd = '0, wb_rd;
    logic        bus_req, bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0, wb_valid, wb_err;
    int          n_chk = 0, n_pass = 0;

    load_data_unit dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_fun3(ld_fun3), .ld_rd(ld_rd), .flush(flush), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic void ref_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                                     input logic err, output logic fault, output logic [31:0] d, output logic e);
        logic [31:0] b, h;
        fault = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef LOAD_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) fault = 1'b1;
        if (f3 == 3'd2 && (addr % 4) != 0) fault = 1'b1;
`endif
        b = (rdata >> (8 * (addr % 4))) % 256;
        h = (rdata >> (16 * ((addr / 2) % 2))) % 65536;
        case (f3)
            3'd0:    d = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    d = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    d = rdata;
            3'd4:    d = b;
            3'd5:    d = h;
            default: d = 32'd0;
        endcase
        e = fault || err;
        if (e) d = 32'd0;
    endfunction

    // Issues one load, then plays the bus for a fixed window, recording what the DUT did. Cycle 1 = accept + 1.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] rdata, input logic err, input int gnt_dly, input int rv_dly,
                            input int flush_c, output int n_wb, output int wb_c, output logic [31:0] wbd,
                            output logic wbe, output logic [4:0] wbr, output int n_req, output bit addr_ok,
                            output int ready_c);
        bit granted = 0;
        int req_wait = 0, rv_c = -1;
        n_wb = 0; wb_c = -1; wbd = '0; wbe = 1'b0; wbr = '0; n_req = 0; addr_ok = 1; ready_c = -1;
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = addr; ld_fun3 = f3; ld_rd = rd;
        @(negedge clk);
        ld_valid = 1'b0; ld_addr = $urandom; ld_fun3 = 3'($urandom_range(0, 7)); ld_rd = 5'($urandom_range(0, 31));
        for (int c = 1; c <= 24; c++) begin
            flush = (c == flush_c);
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
            if (bus_req && !granted) begin
                if (req_wait == gnt_dly) begin bus_gnt = 1'b1; granted = 1; rv_c = c + 1 + rv_dly; end
                else req_wait++;
            end
            if (c == rv_c) begin bus_rvalid = 1'b1; bus_rdata = rdata; bus_err = err; end
            #1;
            if (wb_valid) begin
                n_wb++;
                if (wb_c < 0) begin wb_c = c; wbd = wb_data; wbe = wb_err; wbr = wb_rd; end
            end
            if (bus_req) begin
                n_req++;
                if (bus_addr !== {addr[31:2], 2'b00}) addr_ok = 0;
            end
            if (ld_ready && ready_c < 0) ready_c = c;
            @(negedge clk);
        end
        flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (bus_req !== 1'b0) $display("FAIL rst_bus_req: got %b want 0", bus_req); else n_pass++;
        n_chk++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b want 0", wb_valid); else n_pass++;
        n_chk++; if (wb_err !== 1'b0) $display("FAIL rst_wb_err: got %b want 0", wb_err); else n_pass++;
        n_chk++; if (bus_addr !== 32'd0) $display("FAIL rst_bus_addr: got %h want 0", bus_addr); else n_pass++;
        n_chk++; if (wb_data !== 32'd0 || wb_rd !== 5'd0) $display("FAIL rst_wb: got %h/%0d want 0/0", wb_data, wb_rd); else n_pass++;
        n_chk++; if (ld_ready !== 1'b1) $display("FAIL rst_ld_ready: got %b want 1", ld_ready); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int nw, wc, nr, rc; logic [31:0] d; logic e; logic [4:0] r; bit ao;
        run_load(32'h103, 3'b000, 5'd9, 32'h80FF_1234, 1'b0, 0, 0, 0, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (d !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", d); else n_pass++;
        n_chk++; if (wc !== 3 || nw !== 1) $display("FAIL lb_latency: got cycle %0d x%0d want 3 x1", wc, nw); else n_pass++;
        n_chk++; if (e !== 1'b0 || r !== 5'd9) $display("FAIL lb_err_rd: got %b/%0d want 0/9", e, r); else n_pass++;
        run_load(32'h102, 3'b101, 5'd3, 32'h80FF_1234, 1'b0, 0, 0, 0, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (d !== 32'h0000_80FF) $display("FAIL lhu_data: got %h want 000080ff", d); else n_pass++;
        run_load(32'h102, 3'b001, 5'd3, 32'h80FF_1234, 1'b0, 0, 0, 0, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (d !== 32'hFFFF_80FF) $display("FAIL lh_data: got %h want ffff80ff", d); else n_pass++;
        run_load(32'h200, 3'b010, 5'd4, 32'hA5A5_0F0F, 1'b0, 3, 1, 0, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (nr !== 4 || !ao) $display("FAIL lw_req_hold: got %0d cycles addr_ok %0d want 4 1", nr, ao); else n_pass++;
        n_chk++; if (nw !== 1 || d !== 32'hA5A5_0F0F) $display("FAIL lw_data: got x%0d %h want x1 a5a50f0f", nw, d); else n_pass++;
        run_load(32'h300, 3'b010, 5'd5, 32'hDEAD_BEEF, 1'b0, 0, 2, 2, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (nw !== 0) $display("FAIL flush_wait_wb: got %0d pulses want 0", nw); else n_pass++;
        n_chk++; if (rc !== 5) $display("FAIL flush_wait_ready: got cycle %0d want 5", rc); else n_pass++;
        run_load(32'h44, 3'b010, 5'd6, 32'h1234_5678, 1'b1, 0, 0, 0, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (e !== 1'b1 || d !== 32'd0) $display("FAIL bus_err: got %b/%h want 1/0", e, d); else n_pass++;
        run_load(32'h48, 3'b011, 5'd7, 32'h1234_5678, 1'b0, 0, 0, 0, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (nr !== 0 || e !== 1'b1 || nw !== 1) $display("FAIL bad_fun3: got req %0d err %b x%0d want 0 1 x1", nr, e, nw); else n_pass++;
        run_load(32'h101, 3'b010, 5'd8, 32'h1122_3344, 1'b0, 0, 0, 0, nw, wc, d, e, r, nr, ao, rc);
`ifdef LOAD_MISALIGN_TRAP_EN
        n_chk++; if (nr !== 0 || e !== 1'b1 || d !== 32'd0) $display("FAIL lw_misalign: got req %0d err %b %h want 0 1 0", nr, e, d); else n_pass++;
`else
        n_chk++; if (nr !== 1 || !ao || d !== 32'h1122_3344) $display("FAIL lw_misalign: got req %0d addr_ok %0d %h want 1 1 11223344", nr, ao, d); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int nw, wc, nr, rc, gd, rd_, fc, g, rv, x_nw, x_nr, x_rc; logic [31:0] d, a, rdata, xd;
        logic e, err, fault, xe; logic [4:0] r, rdst; logic [2:0] f3; bit ao;
        for (int i = 0; i < 80; i++) begin
            a = $urandom; f3 = 3'($urandom_range(0, 7)); rdata = $urandom; rdst = 5'($urandom_range(0, 31));
            err = ($urandom_range(0, 7) == 0); gd = $urandom_range(0, 4); rd_ = $urandom_range(0, 4);
            ref_load(a, f3, rdata, err, fault, xd, xe);
            g = 1 + gd; rv = g + 1 + rd_;
            fc = (!fault && $urandom_range(0, 3) == 0) ? $urandom_range(1, rv + 1) : 0;
            if (fault)             begin x_nr = 0;  x_nw = 1; x_rc = 2;      end
            else if (fc == 0 || fc > rv) begin x_nr = g; x_nw = 1; x_rc = rv + 2; end
            else if (fc < g)       begin x_nr = fc; x_nw = 0; x_rc = fc + 1; end
            else                   begin x_nr = g;  x_nw = 0; x_rc = rv + 1; end
            run_load(a, f3, rdst, rdata, err, gd, rd_, fc, nw, wc, d, e, r, nr, ao, rc);
            n_chk++; if (nw !== x_nw) $display("FAIL rnd%0d_wb_count: got %0d want %0d", i, nw, x_nw); else n_pass++;
            n_chk++; if (nr !== x_nr || !ao) $display("FAIL rnd%0d_bus_req: got %0d addr_ok %0d want %0d 1", i, nr, ao, x_nr); else n_pass++;
            n_chk++; if (rc !== x_rc) $display("FAIL rnd%0d_ready: got cycle %0d want %0d", i, rc, x_rc); else n_pass++;
            if (x_nw == 1) begin
                n_chk++;
                if (d !== xd || e !== xe || r !== rdst || wc !== (fault ? 1 : rv + 1))
                    $display("FAIL rnd%0d_wb: got %h/%b/%0d@%0d want %h/%b/%0d@%0d (a=%h f3=%0d)",
                             i, d, e, r, wc, xd, xe, rdst, fault ? 1 : rv + 1, a, f3);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        int nw, wc, nr, rc; logic [31:0] d; logic e; logic [4:0] r; bit ao;
        @(negedge clk); ld_valid = 1'b1; ld_addr = 32'h40; ld_fun3 = 3'b010; ld_rd = 5'd7;
        @(negedge clk); ld_valid = 1'b0; bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (ld_ready !== 1'b1 || bus_req !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL async_rst_state: got ready %b req %b wb %b want 1 0 0", ld_ready, bus_req, wb_valid); else n_pass++;
        n_chk++; if (bus_addr !== 32'd0 || wb_rd !== 5'd0) $display("FAIL async_rst_regs: got %h/%0d want 0/0", bus_addr, wb_rd); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        run_load(32'h8, 3'b100, 5'd2, 32'h00C3_0000, 1'b0, 1, 0, 0, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (nw !== 1 || d !== 32'h0000_0000 || wc !== 4) $display("FAIL post_rst_lbu: got x%0d %h@%0d want x1 0@4", nw, d, wc); else n_pass++;
        run_load(32'hA, 3'b100, 5'd2, 32'h00C3_0000, 1'b0, 0, 0, 0, nw, wc, d, e, r, nr, ao, rc);
        n_chk++; if (d !== 32'h0000_00C3) $display("FAIL lbu_zext: got %h want 000000c3", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
